// File: rtl/card_shoe.sv
// ---------------------------------------------------------------------------
// card_shoe
//
// Multi-deck blackjack shoe that deals without replacement. The shoe keeps a
// remaining count for each rank (1 = ace .. 10 = ten/J/Q/K). A deal picks a
// weighted-random rank: a free-running 16-bit Galois LFSR is scaled into a
// card index below cardsRemaining. The rank counts are then walked one rank
// per cycle until the index falls inside a rank's bucket. That rank is dealt
// and decremented. A shuffle refills every rank to its full-shoe value.
//
// Optional feature: define SHOE_COUNT_EN to add the runningCount port. This
// port carries a registered, saturating hi-lo count of the dealt cards.
//
// Ports:
//   clk            in   1        rising-edge clock
//   reset          in   1        asynchronous, active-high reset
//   requestCard    in   1        deal request, only looked at in IDLE
//   shuffle        in   1        refill request, only looked at in IDLE
//                                (wins over requestCard)
//   dealtCard      out  4        dealt rank 1..10, 0 when cardValid is low
//   cardValid      out  1        one-cycle pulse marking dealtCard
//   busy           out  1        high whenever the FSM is not in IDLE
//   cardsRemaining out  REM_W    cards left in the shoe
//   lowShoe        out  1        cardsRemaining < RESHUFFLE_THRESHOLD
//   shoeEmpty      out  1        cardsRemaining == 0
//   runningCount   out  COUNT_W  signed hi-lo count (SHOE_COUNT_EN only)
// ---------------------------------------------------------------------------
module card_shoe #(
    parameter int          NUM_DECKS           = 1,
    parameter int          RESHUFFLE_THRESHOLD = 13,
    parameter logic [15:0] SEED                = 16'hACE1,
`ifdef SHOE_COUNT_EN
    parameter int          COUNT_W             = 8,
`endif
    localparam int         REM_W               = $clog2(52 * NUM_DECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              requestCard,
    input  logic              shuffle,
    output logic [3:0]        dealtCard,
    output logic              cardValid,
    output logic              busy,
    output logic [REM_W-1:0]  cardsRemaining,
    output logic              lowShoe,
`ifdef SHOE_COUNT_EN
    output logic              shoeEmpty,
    output logic signed [COUNT_W-1:0] runningCount
`else
    output logic              shoeEmpty
`endif
);

    localparam logic [REM_W-1:0] FULL_RANK = REM_W'(4 * NUM_DECKS);
    localparam logic [REM_W-1:0] FULL_TEN  = REM_W'(16 * NUM_DECKS);
    localparam logic [REM_W-1:0] FULL_SHOE = REM_W'(52 * NUM_DECKS);

    typedef enum logic [2:0] {IDLE, SCALE, SEARCH, DEAL, REFILL} state_t;

    state_t           state;
    state_t           next_state;
    logic [15:0]      lfsr;
    logic [REM_W-1:0] idx;
    logic [3:0]       rank;
    logic [3:0]       sel;
    logic [REM_W-1:0] cnt [1:10];
    logic             hit;

    // The status flags come straight from the remaining-card count. They
    // therefore move on the same edge that the deal or refill updates it.
    assign busy      = (state != IDLE);
    assign shoeEmpty = (cardsRemaining == '0);
    assign lowShoe   = (32'(cardsRemaining) < 32'(RESHUFFLE_THRESHOLD));

    // The search index lands inside the bucket of the rank under inspection.
    assign hit = (idx < cnt[rank]);

    // State register. Reset mid-deal simply abandons the deal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Requests are only honoured in IDLE, so anything
    // raised while busy is dropped. Shuffle takes priority over a deal.
    // An empty shoe ignores deal requests.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (shuffle) begin
                    next_state = REFILL;
                end else if (requestCard && !shoeEmpty) begin
                    next_state = SCALE;
                end
            end
            SCALE:   next_state = SEARCH;
            SEARCH:  if (hit) next_state = DEAL;
            DEAL:    next_state = IDLE;
            REFILL:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: LFSR, rank counts, search registers and the card outputs.
    // SCALE maps the LFSR onto [0, cardsRemaining) with a multiply-high, so
    // each remaining card is roughly equally likely. SEARCH subtracts whole
    // rank buckets until the index lands in one. Empty ranks have a
    // zero-size bucket and are skipped without special handling. Since idx
    // stays below the total count, the walk always stops by rank 10.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr           <= SEED;
            idx            <= '0;
            rank           <= 4'd1;
            sel            <= 4'd1;
            dealtCard      <= 4'd0;
            cardValid      <= 1'b0;
            cardsRemaining <= FULL_SHOE;
            for (int i = 1; i <= 10; i++) begin
                cnt[i] <= (i == 10) ? FULL_TEN : FULL_RANK;
            end
        end else begin
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            cardValid <= 1'b0;
            dealtCard <= 4'd0;
            case (state)
                SCALE: begin
                    idx  <= REM_W'((32'(lfsr) * 32'(cardsRemaining)) >> 16);
                    rank <= 4'd1;
                end
                SEARCH: begin
                    if (hit) begin
                        sel <= rank;
                    end else begin
                        idx  <= idx - cnt[rank];
                        rank <= rank + 4'd1;
                    end
                end
                DEAL: begin
                    cnt[sel]       <= cnt[sel] - REM_W'(1);
                    cardsRemaining <= cardsRemaining - REM_W'(1);
                    dealtCard      <= sel;
                    cardValid      <= 1'b1;
                end
                REFILL: begin
                    cardsRemaining <= FULL_SHOE;
                    for (int i = 1; i <= 10; i++) begin
                        cnt[i] <= (i == 10) ? FULL_TEN : FULL_RANK;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHOE_COUNT_EN
    localparam logic signed [COUNT_W-1:0] CNT_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
    localparam logic signed [COUNT_W-1:0] CNT_MIN = {1'b1, {(COUNT_W-1){1'b0}}};

    // Hi-lo count: low cards (2..6) add one and aces/tens subtract one.
    // The count sticks at the signed limits instead of wrapping, and a
    // refill clears it because the shoe starts over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            runningCount <= '0;
        end else if (state == REFILL) begin
            runningCount <= '0;
        end else if (state == DEAL) begin
            if (sel >= 4'd2 && sel <= 4'd6) begin
                if (runningCount != CNT_MAX) begin
                    runningCount <= runningCount + COUNT_W'(1);
                end
            end else if (sel == 4'd1 || sel == 4'd10) begin
                if (runningCount != CNT_MIN) begin
                    runningCount <= runningCount - COUNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
